// File: rtl/sl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sl_pkg : shared types and constants for the SL transmit scheduler |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package sl_pkg;

  localparam int SL_DATA_W = 32;
  localparam int SL_CFG_W  = 10;

  // Transmitter config word field positions
  localparam int BQL  = 0;
  localparam int BQH  = 5;
  localparam int IRQM = 6;
  localparam int FQL  = 7;
  localparam int FQH  = 9;

  localparam logic [SL_CFG_W-1:0] SL_CFG_RST = 10'h108;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG      = 3'd1,
    S_CHECK    = 3'd2,
    S_ARM      = 3'd3,
    S_SEND     = 3'd4,
    S_WAIT_LOW = 3'd5,
    S_DONE     = 3'd6
  } sl_state_e;

endpackage
`default_nettype wire

// File: rtl/sl_tx_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sl_tx_scheduler_if : requester and transmitter side signal bundle |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface sl_tx_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int CFG_W  = 10,
  parameter int IDW    = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*CFG_W-1:0]  req_cfg;

  logic [DATA_W-1:0]       tx_data;
  logic                    tx_send;
  logic [CFG_W-1:0]        tx_cfg;
  logic                    tx_cfg_we;
  logic [CFG_W-1:0]        tx_cfg_rd;
  logic                    tx_busy;

  logic                    done_valid;
  logic [IDW-1:0]          done_id;
  logic                    done_err;

  modport master (
    input  req_valid, req_data, req_cfg, tx_cfg_rd, tx_busy,
    output req_ready, tx_data, tx_send, tx_cfg, tx_cfg_we,
           done_valid, done_id, done_err
  );

  modport slave (
    output req_valid, req_data, req_cfg, tx_cfg_rd, tx_busy,
    input  req_ready, tx_data, tx_send, tx_cfg, tx_cfg_we,
           done_valid, done_id, done_err
  );

endinterface
`default_nettype wire

// File: rtl/sl_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sl_rr_arbiter : combinational round-robin pick from a start index |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module sl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic [N_REQ-1:0] gnt_onehot_o,
  output logic [IDW-1:0]   gnt_id_o,
  output logic             any_o
);

  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    gnt_onehot_o = '0;
    gnt_id_o     = '0;
    any_o        = 1'b0;
    idx          = 0;
    idx_w        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(rr_ptr_i) + k) % N_REQ;
      idx_w = IDW'(idx);
      if (!any_o && req_i[idx_w]) begin
        any_o               = 1'b1;
        gnt_onehot_o[idx_w] = 1'b1;
        gnt_id_o            = idx_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sl_tx_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sl_tx_scheduler : shares one SL transmitter between N requesters  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module sl_tx_scheduler
  import sl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = SL_DATA_W,
  parameter int CFG_W    = SL_CFG_W,
  parameter int START_TO = 8,
  parameter int IDW      = $clog2(N_REQ)
) (
  input logic         clk,
  input logic         rst,
  sl_tx_scheduler_if.master bus_io
);

  localparam int TO_W = (START_TO > 1) ? $clog2(START_TO) : 1;

  sl_state_e         state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [CFG_W-1:0]  cfg_q;
  logic [IDW-1:0]    id_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              retry_q;
  logic              err_q;
  logic              tx_send_q;
  logic              tx_cfg_we_q;
  logic              done_valid_q;
  logic              done_err_q;

  logic [N_REQ-1:0]  w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_any;
  logic              w_grant;
  logic [IDW-1:0]    rr_ptr_d;
  logic [DATA_W-1:0] w_sel_data;
  logic [CFG_W-1:0]  w_sel_cfg;

  sl_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req_i        (bus_io.req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .gnt_onehot_o (w_gnt),
    .gnt_id_o     (w_gnt_id),
    .any_o        (w_any)
  );

  assign w_grant  = (state_q == S_IDLE) && w_any && !bus_io.tx_busy;
  assign rr_ptr_d = (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);

  always_comb begin
    w_sel_data = '0;
    w_sel_cfg  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_data |= bus_io.req_data[i*DATA_W +: DATA_W];
        w_sel_cfg  |= bus_io.req_cfg[i*CFG_W +: CFG_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      cfg_q        <= CFG_W'(SL_CFG_RST);
      id_q         <= '0;
      to_cnt_q     <= '0;
      retry_q      <= 1'b0;
      err_q        <= 1'b0;
      tx_send_q    <= 1'b0;
      tx_cfg_we_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      tx_cfg_we_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_grant) begin
            data_q   <= w_sel_data;
            cfg_q    <= w_sel_cfg;
            id_q     <= w_gnt_id;
            rr_ptr_q <= rr_ptr_d;
            retry_q  <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
            // Skip the write when the transmitter already holds this config
            if (w_sel_cfg == bus_io.tx_cfg_rd) begin
              state_q <= S_ARM;
            end else begin
              state_q     <= S_CFG;
              tx_cfg_we_q <= 1'b1;
            end
          end
        end
        S_CFG: state_q <= S_CHECK;
        S_CHECK: begin
          if (bus_io.tx_cfg_rd == cfg_q) begin
            state_q <= S_ARM;
          end else if (!retry_q) begin
            retry_q     <= 1'b1;
            state_q     <= S_CFG;
            tx_cfg_we_q <= 1'b1;
          end else begin
            err_q        <= 1'b1;
            state_q      <= S_DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
          end
        end
        S_ARM: begin
          state_q   <= S_SEND;
          tx_send_q <= 1'b1;
          to_cnt_q  <= '0;
        end
        S_SEND: begin
          if (bus_io.tx_busy) begin
            state_q   <= S_WAIT_LOW;
            tx_send_q <= 1'b0;
          end else if (to_cnt_q == TO_W'(START_TO - 1)) begin
            state_q      <= S_DONE;
            tx_send_q    <= 1'b0;
            err_q        <= 1'b1;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WAIT_LOW: begin
          if (!bus_io.tx_busy) begin
            state_q      <= S_DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= err_q;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Accept pulse is combinational so the word is captured in the grant cycle
  assign bus_io.req_ready  = (w_grant && !rst) ? w_gnt : '0;
  assign bus_io.tx_data    = data_q;
  assign bus_io.tx_cfg     = cfg_q;
  assign bus_io.tx_send    = tx_send_q;
  assign bus_io.tx_cfg_we  = tx_cfg_we_q;
  assign bus_io.done_valid = done_valid_q;
  assign bus_io.done_id    = id_q;
  assign bus_io.done_err   = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sl_tx_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sl_tx_scheduler : directed bench with a small transmitter model|
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_sl_tx_scheduler;
  import sl_pkg::*;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int CW       = 10;
  localparam int STO      = 8;
  localparam int BUSY_LEN = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sl_tx_scheduler_if #(.N_REQ(N), .DATA_W(DW), .CFG_W(CW)) sif ();

  sl_tx_scheduler #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .CFG_W    (CW),
    .START_TO (STO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (sif)
  );

  // Transmitter model: config register plus a fixed-length busy window
  logic [CW-1:0] m_cfg;
  int            m_busy;
  logic          m_busy_en    = 1'b1;
  logic          m_ignore_cfg = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cfg  <= 10'h108;
      m_busy <= 0;
    end else begin
      if (sif.tx_cfg_we && !m_ignore_cfg) m_cfg <= sif.tx_cfg;
      if (m_busy != 0) m_busy <= m_busy - 1;
      else if (sif.tx_send && m_busy_en) m_busy <= BUSY_LEN;
    end
  end
  assign sif.tx_cfg_rd = m_cfg;
  assign sif.tx_busy   = (m_busy != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_we = 0, n_send = 0, n_done = 0, n_rdy_busy = 0;
  int          last_acc = 0, last_send_rise = 0, last_done = 0;
  logic [CW-1:0] last_we_val = '0;
  logic [1:0]  last_done_id = '0;
  logic        last_done_err = 1'b0;
  logic        prev_send = 1'b0;
  int          grant_q[$];

  always @(negedge clk) begin
    if (|sif.req_ready) begin
      last_acc = cyc;
      for (int i = 0; i < N; i++) if (sif.req_ready[i]) grant_q.push_back(i);
      if (sif.tx_busy) n_rdy_busy++;
    end
    if (sif.tx_cfg_we) begin
      n_we++;
      last_we_val = sif.tx_cfg;
    end
    if (sif.tx_send) begin
      n_send++;
      if (!prev_send) last_send_rise = cyc;
    end
    prev_send = sif.tx_send;
    if (sif.done_valid) begin
      n_done++;
      last_done     = cyc;
      last_done_id  = sif.done_id;
      last_done_err = sif.done_err;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_q.size() < n && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    if (grant_q.size() < n) chk("grant_timeout", 32'(grant_q.size()), 32'(n));
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (n_done < n && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    if (n_done < n) chk("done_timeout", 32'(n_done), 32'(n));
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic [CW-1:0] c);
    sif.req_data[i*DW +: DW] = d;
    sif.req_cfg[i*CW +: CW]  = c;
  endtask

  // Raise one requester, drop it right after its accept, wait for the done
  task automatic run_one(input int i);
    int bg;
    int bd;
    bg = grant_q.size();
    bd = n_done;
    @(posedge clk); #1;
    sif.req_valid[i] = 1'b1;
    wait_grants(bg + 1, 30);
    @(posedge clk); #1;
    sif.req_valid[i] = 1'b0;
    wait_dones(bd + 1, 120);
  endtask

  int b_we, b_send, b_g, b_done, b_rb;

  initial begin
    sif.req_valid = '1;
    sif.req_data  = '0;
    sif.req_cfg   = {N{10'h108}};
    repeat (2) @(posedge clk); #1;

    chk("rst_ready",    32'(sif.req_ready), 32'h0);
    chk("rst_send",     32'(sif.tx_send), 32'h0);
    chk("rst_cfg_we",   32'(sif.tx_cfg_we), 32'h0);
    chk("rst_done",     32'(sif.done_valid), 32'h0);
    chk("rst_done_err", 32'(sif.done_err), 32'h0);
    chk("rst_done_id",  32'(sif.done_id), 32'h0);
    chk("rst_tx_cfg",   32'(sif.tx_cfg), 32'h108);
    chk("rst_tx_data",  sif.tx_data, 32'h0);
    chk("rst_state",    32'(dut.state_q), 32'(S_IDLE));
    sif.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Config already matches: no write, send two cycles after accept
    set_req(0, 32'hA5A5_0001, 10'h108);
    b_we = n_we; b_send = n_send; b_g = grant_q.size();
    run_one(0);
    chk("t1_gnt",      32'(grant_q[b_g]), 32'd0);
    chk("t1_we",       32'(n_we - b_we), 32'd0);
    chk("t1_lat",      32'(last_send_rise - last_acc), 32'd2);
    chk("t1_sends",    32'(n_send - b_send), 32'd2);
    chk("t1_done_lat", 32'(last_done - last_acc), 32'd44);
    chk("t1_id",       32'(last_done_id), 32'd0);
    chk("t1_err",      32'(last_done_err), 32'd0);

    // Config differs: one write, send four cycles after accept
    set_req(1, 32'h5A5A_0002, 10'h190);
    b_we = n_we; b_g = grant_q.size();
    run_one(1);
    chk("t2_gnt",      32'(grant_q[b_g]), 32'd1);
    chk("t2_we",       32'(n_we - b_we), 32'd1);
    chk("t2_we_val",   32'(last_we_val), 32'h190);
    chk("t2_lat",      32'(last_send_rise - last_acc), 32'd4);
    chk("t2_done_lat", 32'(last_done - last_acc), 32'd46);
    chk("t2_id",       32'(last_done_id), 32'd1);
    chk("t2_err",      32'(last_done_err), 32'd0);

    // Reset returns the pointer to zero, then all four contend
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t3_rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'hC0DE_0000 + 32'(i), 10'h108);
    b_g = grant_q.size(); b_done = n_done; b_rb = n_rdy_busy;
    sif.req_valid = '1;
    wait_grants(b_g + 5, 400);
    @(posedge clk); #1;
    sif.req_valid = '0;
    wait_dones(b_done + 5, 200);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t3_order%0d", k), 32'(grant_q[b_g + k]), 32'(k % N));
    chk("t3_rdy_busy", 32'(n_rdy_busy - b_rb), 32'd0);
    chk("t3_ptr",      32'(dut.rr_ptr_q), 32'd1);

    // Transmitter never goes busy: eight send cycles then an error done
    m_busy_en = 1'b0;
    set_req(2, 32'h0000_0022, 10'h108);
    set_req(3, 32'h0000_0033, 10'h108);
    b_g = grant_q.size(); b_done = n_done; b_send = n_send;
    @(posedge clk); #1;
    sif.req_valid[2] = 1'b1;
    sif.req_valid[3] = 1'b1;
    wait_grants(b_g + 1, 30);
    @(posedge clk); #1;
    sif.req_valid[2] = 1'b0;
    wait_dones(b_done + 1, 60);
    chk("t4_gnt_a",     32'(grant_q[b_g]), 32'd2);
    chk("t4_sends_a",   32'(n_send - b_send), 32'd8);
    chk("t4_done_lat",  32'(last_done - last_acc), 32'd10);
    chk("t4_id_a",      32'(last_done_id), 32'd2);
    chk("t4_err_a",     32'(last_done_err), 32'd1);
    wait_grants(b_g + 2, 30);
    @(posedge clk); #1;
    sif.req_valid[3] = 1'b0;
    wait_dones(b_done + 2, 60);
    chk("t4_gnt_b",     32'(grant_q[b_g + 1]), 32'd3);
    chk("t4_id_b",      32'(last_done_id), 32'd3);
    chk("t4_err_b",     32'(last_done_err), 32'd1);
    chk("t4_sends_all", 32'(n_send - b_send), 32'd16);

    // Config writes are ignored: write, check, rewrite, check, error
    m_busy_en    = 1'b1;
    m_ignore_cfg = 1'b1;
    set_req(0, 32'h0000_00AA, 10'h3FF);
    b_we = n_we; b_send = n_send; b_g = grant_q.size();
    run_one(0);
    chk("t5_gnt",      32'(grant_q[b_g]), 32'd0);
    chk("t5_we",       32'(n_we - b_we), 32'd2);
    chk("t5_sends",    32'(n_send - b_send), 32'd0);
    chk("t5_done_lat", 32'(last_done - last_acc), 32'd5);
    chk("t5_id",       32'(last_done_id), 32'd0);
    chk("t5_err",      32'(last_done_err), 32'd1);

    // Reset while waiting for busy to fall
    m_ignore_cfg = 1'b0;
    set_req(1, 32'hDEAD_BEEF, 10'h108);
    b_g = grant_q.size();
    @(posedge clk); #1;
    sif.req_valid[1] = 1'b1;
    wait_grants(b_g + 1, 30);
    @(posedge clk); #1;
    sif.req_valid[1] = 1'b0;
    for (int k = 0; k < 20 && dut.state_q != S_WAIT_LOW; k++) begin
      @(negedge clk); #2;
    end
    chk("t6_in_wait", 32'(dut.state_q == S_WAIT_LOW), 32'd1);
    b_done = n_done;
    rst = 1'b1;
    #1;
    chk("t6_send",    32'(sif.tx_send), 32'h0);
    chk("t6_ready",   32'(sif.req_ready), 32'h0);
    chk("t6_done",    32'(sif.done_valid), 32'h0);
    chk("t6_done_id", 32'(sif.done_id), 32'h0);
    chk("t6_data",    sif.tx_data, 32'h0);
    chk("t6_state",   32'(dut.state_q), 32'(S_IDLE));
    chk("t6_ptr",     32'(dut.rr_ptr_q), 32'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(n_done - b_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
